// File: rtl/gps_ack_pkg.sv
// Shared types for the gps_ack scan scheduler: index/phase/magnitude types,
// scheduler states and the per-satellite result record.
package gps_ack_pkg;

   localparam int NUM_SATS = 32;
   localparam int CODE_LEN = 1023;
   localparam int CORR_W   = 12;

   typedef logic [4:0]        sat_idx_t;
   typedef logic [9:0]        code_phase_t;
   typedef logic [CORR_W-1:0] corr_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_COLLECT,
      S_REPORT,
      S_ADVANCE
   } sched_state_t;

   typedef struct packed {
      sat_idx_t    prn;
      code_phase_t phase;
      corr_t       peak;
      logic        detect;
      logic        timeout;
   } ack_res_t;

endpackage

// File: rtl/gps_peak_tracker.sv
// Per-satellite result accumulator: counts correlator strobes, keeps the
// strictly-greatest magnitude with its code phase (ties keep the earliest),
// and times the gap between strobes. The *_nxt outputs include the strobe of
// the current cycle so the scheduler can capture the final result directly.
module gps_peak_tracker
   import gps_ack_pkg::*;
#(
   parameter int NUM_PHASES = 1023,
   parameter int TIMEOUT    = 65535,
   parameter int INT_W      = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             strobe,
   input  logic             tick,
   input  code_phase_t      code_phase,
   input  logic [INT_W-1:0] integrator,
   output logic [INT_W-1:0] peak_nxt,
   output code_phase_t      phase_nxt,
   output logic             done,
   output logic             tmo
);

   localparam logic [9:0]  LAST_CNT = 10'(NUM_PHASES - 1);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   logic [9:0]       count;
   logic [15:0]      timer;
   logic [INT_W-1:0] peak;
   code_phase_t      peak_phase;
   logic             upd;

   assign upd       = strobe && (integrator > peak);
   assign peak_nxt  = upd ? integrator : peak;
   assign phase_nxt = upd ? code_phase : peak_phase;
   // Final strobe of the satellite, counting the one arriving now.
   assign done      = strobe && (count == LAST_CNT);
   // The idle cycle that brings the gap up to TIMEOUT.
   assign tmo       = tick && !strobe && (timer >= TMO_LAST);

   // Count, peak/phase and gap timer; frozen whenever neither strobe nor tick.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count      <= '0;
         timer      <= '0;
         peak       <= '0;
         peak_phase <= '0;
      end else if (clr) begin
         count      <= '0;
         timer      <= '0;
         peak       <= '0;
         peak_phase <= '0;
      end else if (strobe) begin
         count      <= count + 10'd1;
         timer      <= '0;
         peak       <= peak_nxt;
         peak_phase <= phase_nxt;
      end else if (tick) begin
         timer <= (timer == 16'hFFFF) ? timer : timer + 16'd1;
      end
   end

endmodule

// File: rtl/gps_ack_sched.sv
// Scan scheduler for the single gps_ack correlator: walks prn_first..prn_last
// (wrapping mod 32), launches one acquisition per satellite, and reports one
// peak/threshold result per satellite over a valid/ready handshake. A new
// satellite is not launched until the previous result is accepted.
module gps_ack_sched
   import gps_ack_pkg::*;
#(
   parameter int NUM_PHASES = 1023,
   parameter int TIMEOUT    = 65535,
   parameter int INT_W      = CORR_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             scan_start,
   input  logic             scan_abort,
   input  logic [4:0]       prn_first,
   input  logic [4:0]       prn_last,
   input  logic [INT_W-1:0] threshold,
   output logic             ack_start,
   output logic [4:0]       sat0,
   input  logic             corr_complete,
   input  logic [9:0]       code_phase,
   input  logic [INT_W-1:0] integrator,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [4:0]       res_prn,
   output logic [9:0]       res_phase,
   output logic [INT_W-1:0] res_peak,
   output logic             res_detect,
   output logic             res_timeout,
   output logic             busy,
   output logic             scan_done
);

   sched_state_t     state;
   sat_idx_t         cur;
   sat_idx_t         last;
   logic [INT_W-1:0] thr;
   ack_res_t         res;

   logic [INT_W-1:0] peak_nxt;
   code_phase_t      phase_nxt;
   logic             trk_done;
   logic             trk_tmo;
   logic             in_collect;

   assign in_collect = (state == S_COLLECT);

   // Abort takes priority over a same-cycle strobe, so the strobe is masked.
   gps_peak_tracker #(
      .NUM_PHASES(NUM_PHASES),
      .TIMEOUT   (TIMEOUT),
      .INT_W     (INT_W)
   ) u_trk (
      .clk       (clk),
      .rst       (rst),
      .clr       (state == S_LAUNCH),
      .strobe    (corr_complete && in_collect && !scan_abort),
      .tick      (in_collect),
      .code_phase(code_phase),
      .integrator(integrator),
      .peak_nxt  (peak_nxt),
      .phase_nxt (phase_nxt),
      .done      (trk_done),
      .tmo       (trk_tmo)
   );

   assign res_prn     = res.prn;
   assign res_phase   = res.phase;
   assign res_peak    = res.peak;
   assign res_detect  = res.detect;
   assign res_timeout = res.timeout;

   // Scheduler FSM with registered pulses, handshake and result record.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         cur       <= '0;
         last      <= '0;
         thr       <= '0;
         sat0      <= '0;
         ack_start <= 1'b0;
         res_valid <= 1'b0;
         res       <= '0;
         busy      <= 1'b0;
         scan_done <= 1'b0;
      end else begin
         ack_start <= 1'b0;
         scan_done <= 1'b0;
         if (scan_abort && state != S_IDLE) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res       <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (scan_start && !scan_abort) begin
                     cur   <= prn_first;
                     last  <= prn_last;
                     thr   <= threshold;
                     busy  <= 1'b1;
                     state <= S_LAUNCH;
                  end
               end
               S_LAUNCH: begin
                  sat0      <= cur;
                  ack_start <= 1'b1;
                  state     <= S_COLLECT;
               end
               S_COLLECT: begin
                  if (trk_done || trk_tmo) begin
                     res.prn     <= cur;
                     res.phase   <= phase_nxt;
                     res.peak    <= peak_nxt;
                     res.detect  <= !trk_tmo && (peak_nxt >= thr);
                     res.timeout <= trk_tmo;
                     res_valid   <= 1'b1;
                     state       <= S_REPORT;
                  end
               end
               S_REPORT: begin
                  if (res_ready) begin
                     res_valid <= 1'b0;
                     state     <= S_ADVANCE;
                  end
               end
               S_ADVANCE: begin
                  if (cur == last) begin
                     scan_done <= 1'b1;
                     busy      <= 1'b0;
                     state     <= S_IDLE;
                  end else begin
                     cur   <= cur + 5'd1;
                     state <= S_LAUNCH;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/gps_ack_sched.md
Name: gps_ack_sched

Overview:
- Sequences the single gps_ack correlator across a range of satellite indices.
- For each satellite: pulses ack_start with sat0, collects the corr_complete/code_phase/integrator results, and tracks the peak.
- Issues one threshold-detection result per satellite on a valid/ready output.
- Sits between the system control plane and gps_ack; the correlator and its adc_clk/sample inputs are untouched.

Parameters:
- NUM_PHASES, 1023: corr_complete events per satellite (one per code phase).
- TIMEOUT, 65535: max clk cycles between consecutive corr_complete events before the satellite is abandoned.
- INT_W, 12: integrator width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- scan_start  in  1  one-cycle request to begin a scan; ignored while busy
- scan_abort  in  1  terminate the scan
- prn_first  in  5  first satellite index, sampled on scan_start
- prn_last  in  5  last satellite index, sampled on scan_start
- threshold  in  INT_W  detection threshold, sampled on scan_start
- ack_start  out  1  one-cycle start pulse to gps_ack
- sat0  out  5  satellite index to gps_ack; held stable for the whole satellite
- corr_complete  in  1  result strobe from gps_ack
- code_phase  in  10  code phase of the current result
- integrator  in  INT_W  correlation magnitude of the current result
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_prn  out  5  satellite index of the result
- res_phase  out  10  code phase of the peak
- res_peak  out  INT_W  peak magnitude
- res_detect  out  1  res_peak >= threshold, and no timeout
- res_timeout  out  1  satellite abandoned on timeout
- busy  out  1  scan in progress
- scan_done  out  1  one-cycle pulse when the final result is accepted

Behaviour:
- Reset (rst low, async): state IDLE. All outputs 0, including sat0, ack_start, res_*, busy and scan_done.
- States: IDLE, LAUNCH, COLLECT, REPORT, ADVANCE.
- IDLE:
  - On scan_start, latch prn_first, prn_last and threshold; cur = prn_first.
  - Go to LAUNCH; busy = 1 from the next cycle.
- LAUNCH:
  - sat0 = cur; ack_start = 1 for exactly one cycle.
  - Clear peak = 0, peak_phase = 0, count = 0, timer = 0; go to COLLECT.
- COLLECT, on each corr_complete:
  - count += 1; timer = 0.
  - If integrator > peak (strict), load peak and peak_phase from integrator and code_phase. Ties keep the earliest phase.
  - When count reaches NUM_PHASES (including the event just counted), go to REPORT.
- COLLECT, with no event:
  - timer += 1.
  - At timer == TIMEOUT, set res_timeout = 1 and go to REPORT with the peak so far; res_detect is forced to 0.
- REPORT:
  - res_valid = 1; res_* are stable while res_valid && !res_ready.
  - On res_valid && res_ready, go to ADVANCE. Hold 0 cycles if res_ready is already high.
- ADVANCE:
  - If cur == prn_last: pulse scan_done, clear busy, go to IDLE.
  - Otherwise cur = cur + 1 mod 32 and go to LAUNCH. prn_first > prn_last therefore wraps 31 -> 0.
  - prn_first == prn_last scans exactly one satellite.
- Throughput: the next ack_start is not issued until the previous result is accepted. Backpressure therefore never drops correlator results.
- corr_complete outside COLLECT is ignored, including stray events after a timeout.
- corr_complete in the cycle COLLECT is entered from LAUNCH is counted.
- scan_abort, in any non-IDLE state:
  - Next state is IDLE; busy, res_valid and ack_start are 0 next cycle.
  - No scan_done pulse and no partial result.
  - scan_abort has priority over a simultaneous handshake or corr_complete.
- scan_start coincident with scan_abort in IDLE: abort wins; the start is ignored.
- Arithmetic: peak compare is unsigned INT_W. count is 10 bits (NUM_PHASES ≤ 1023). timer is 16 bits and saturates.

Decomposition:
- Shared package gps_ack_pkg holds:
  - sat_idx_t (5-bit), code_phase_t (10-bit), corr_t (INT_W).
  - NUM_SATS = 32, CODE_LEN = 1023.
  - The scheduler state enum.
  - Result struct {prn, phase, peak, detect, timeout}.
- One natural sub-module, gps_peak_tracker: count, max-with-phase and timeout timer, with clear/strobe inputs and done/timeout outputs. The FSM stays in gps_ack_sched.

Test Plan:
- prn_first = prn_last = 4, threshold = 100; model streams 1023 results with integrator = 150 at phase 517, else 20 -> one ack_start with sat0 = 4; result prn = 4, phase = 517, peak = 150, detect = 1; scan_done pulse.
- prn 30..1 (wrap), all integrators 50, threshold 100 -> sat0 sequence 30, 31, 0, 1; four results with detect = 0; exactly 4 ack_start pulses.
- Peak 200 at phases 10 and 900 (tie) -> res_phase = 10; res_ready held low 50 cycles -> res_* stable, no new ack_start until the handshake.
- Model stops after 300 results, TIMEOUT = 1000 -> result after 1000 idle cycles with timeout = 1, detect = 0; scan continues to the next satellite.
- scan_abort mid-COLLECT of the second of 3 satellites -> IDLE next cycle, busy = 0, no scan_done, no second result; a new scan_start then runs cleanly.
- rst asserted mid-REPORT -> all outputs 0 immediately (async); after release, scan_start restarts from prn_first.
